// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg
// Shared types and constants for the ALU operation scheduler.
//   state_t        : scheduler FSM states (IDLE, SETTLE, RESP)
//   OP_A..OP_H     : result-mux select codes 0..7 (inputs a..h)
//   DEFAULT_WIDTH  : default operand/result width
//   CNT_W          : settle counter width (SETTLE_CYCLES legal range 1..15)
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] OP_A = 3'd0;
  localparam logic [2:0] OP_B = 3'd1;
  localparam logic [2:0] OP_C = 3'd2;
  localparam logic [2:0] OP_D = 3'd3;
  localparam logic [2:0] OP_E = 3'd4;
  localparam logic [2:0] OP_F = 3'd5;
  localparam logic [2:0] OP_G = 3'd6;
  localparam logic [2:0] OP_H = 3'd7;

  localparam int DEFAULT_WIDTH = 16;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/alu_op_scheduler_if.sv
// alu_op_scheduler_if
// Bundles every non-clock/reset signal of the ALU scheduler.
//   Request ports  : req0_*/req1_* valid/ready handshake with op, a, b
//   ALU side       : alu_a, alu_b, alu_c1..c3 (to ALU), alu_result, alu_cout (from ALU)
//   Response port  : rsp_valid/rsp_ready handshake with rsp_id, rsp_data
//   Status         : busy
// Optional macro ALU_SCHED_FLAGS_EN adds rsp_zero/rsp_carry and hooks up alu_cout.
// Modports: master = requesters, ALU and response consumer; slave = scheduler.
interface alu_op_scheduler_if
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_c1;
  logic             alu_c2;
  logic             alu_c3;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SCHED_FLAGS_EN
  logic             rsp_zero;
  logic             rsp_carry;
`endif

  logic             busy;

`ifdef ALU_SCHED_FLAGS_EN
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_c1, alu_c2, alu_c3,
    output alu_result, alu_cout,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_c1, alu_c2, alu_c3,
    input  alu_result, alu_cout,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry,
    input  rsp_ready,
    output busy
  );
`else
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_c1, alu_c2, alu_c3,
    output alu_result, alu_cout,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  busy
  );

  // alu_cout exists on the bus but the scheduler ignores it without flags.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_c1, alu_c2, alu_c3,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output busy
  );
`endif

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-input round-robin arbiter. The grant is combinational; the pointer
// moves to the non-served requester only when a grant is actually accepted.
//   clk, rst  : clock, synchronous active-high reset (pointer -> requester 0)
//   valid0/1  : request present
//   accept    : the current grant was taken this cycle
//   grant_id  : winning requester (meaningful only when a valid is high)
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant_id
);

  // ptr names the requester favoured when both are valid.
  logic ptr;

  // A lone requester wins regardless of the pointer.
  assign grant_id = (valid0 && valid1) ? ptr : valid1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
// Sequences operations from two requesters onto a shared combinational ALU
// and its 8:1 result mux: grants one request (round-robin), registers the
// operands and selects, waits SETTLE_CYCLES, captures the result and returns
// it with the requester ID on a valid/ready response channel.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_op_scheduler_if.slave (requests, ALU drive/return, response, busy)
// Parameters: WIDTH (operand width), SETTLE_CYCLES (1..15).
// Optional macro ALU_SCHED_FLAGS_EN: capture zero/carry flags with the result.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_scheduler_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_id;
  logic             grant_en;
  logic             accept;
  logic             capture;
  logic             rsp_fire;

  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_op_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
`ifdef ALU_SCHED_FLAGS_EN
  logic             rsp_zero_q;
  logic             rsp_carry_q;
`endif

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid0   (bus.req0_valid),
    .valid1   (bus.req1_valid),
    .accept   (accept),
    .grant_id (grant_id)
  );

  // Ready depends only on state, pointer and valids; held low during reset.
  assign grant_en       = (state_q == IDLE) && !rst;
  assign bus.req0_ready = grant_en && bus.req0_valid && !grant_id;
  assign bus.req1_ready = grant_en && bus.req1_valid &&  grant_id;
  assign accept         = (bus.req0_valid && bus.req0_ready) ||
                          (bus.req1_valid && bus.req1_ready);
  assign capture        = (state_q == SETTLE) && (cnt_q == '0);
  assign rsp_fire       = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = SETTLE;
      SETTLE:  if (capture)  state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Request latch / settle countdown / result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef ALU_SCHED_FLAGS_EN
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
        alu_b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
        alu_op_q <= grant_id ? bus.req1_op : bus.req0_op;
        id_q     <= grant_id;
        cnt_q    <= CNT_LOAD;
      end else if ((state_q == SETTLE) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bus.alu_result;
`ifdef ALU_SCHED_FLAGS_EN
        rsp_zero_q  <= (bus.alu_result == '0);
        rsp_carry_q <= bus.alu_cout;
`endif
      end else if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_c1    = alu_op_q[2];
  assign bus.alu_c2    = alu_op_q[1];
  assign bus.alu_c3    = alu_op_q[0];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef ALU_SCHED_FLAGS_EN
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_carry = rsp_carry_q;
`endif
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler
// Directed bench for alu_op_scheduler (WIDTH=16, SETTLE_CYCLES=2). A small
// ALU model drives alu_result from the registered operands and selects,
// unless an override value is forced for a specific scenario.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic        use_ovr;
  logic [15:0] ovr_val;
  logic [15:0] model_res;

  alu_op_scheduler_if #(.WIDTH(16)) bus ();

  alu_op_scheduler #(.WIDTH(16), .SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU mux model: inputs a..h selected by {c1,c2,c3}.
  always_comb begin
    case ({bus.alu_c1, bus.alu_c2, bus.alu_c3})
      3'd0:    model_res = bus.alu_a;
      3'd1:    model_res = bus.alu_b;
      3'd2:    model_res = bus.alu_a + bus.alu_b;
      3'd3:    model_res = bus.alu_a - bus.alu_b;
      3'd4:    model_res = bus.alu_a & bus.alu_b;
      3'd5:    model_res = bus.alu_a | bus.alu_b;
      3'd6:    model_res = bus.alu_a ^ bus.alu_b;
      default: model_res = ~bus.alu_a;
    endcase
  end
  assign bus.alu_result = use_ovr ? ovr_val : model_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%b rsp_valid=%b want 0 0", bus.busy, bus.rsp_valid);
    end
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.rsp_data !== 16'h0 ||
        {bus.alu_c1, bus.alu_c2, bus.alu_c3} !== 3'b000 || bus.rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_data alu_a=%h alu_b=%h rsp_data=%h want 0", bus.alu_a, bus.alu_b, bus.rsp_data);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    use_ovr = 1'b1;
    ovr_val = 16'hBEEF;
    bus.rsp_ready = 1'b1;
    bus.req0_op = OP_D;
    bus.req0_a = 16'h1234;
    bus.req0_b = 16'h0001;
    bus.req0_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", bus.req0_ready);
    end
    tick();  // accept edge
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.alu_a !== 16'h1234 || bus.alu_b !== 16'h0001) begin
      errors++;
      $display("FAIL single_operands got %h %h want 1234 0001", bus.alu_a, bus.alu_b);
    end
    checks++;
    if ({bus.alu_c1, bus.alu_c2, bus.alu_c3} !== 3'b011) begin
      errors++;
      $display("FAIL single_selects got %b want 011", {bus.alu_c1, bus.alu_c2, bus.alu_c3});
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_settle busy=%b rsp_valid=%b want 1 0", bus.busy, bus.rsp_valid);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got rsp_valid=%b want 0", bus.rsp_valid);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF || bus.rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got v=%b data=%h id=%b want 1 beef 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();  // response handshake edge
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got v=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
    use_ovr = 1'b0;
  endtask

  task automatic test_contention();
    logic [15:0] exp_data [2];
    int n;
    exp_data[0] = 16'h0013;  // 0x0010 + 0x0003
    exp_data[1] = 16'h00FF;  // 0x0100 - 0x0001
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_op = OP_C; bus.req0_a = 16'h0010; bus.req0_b = 16'h0003;
    bus.req1_op = OP_D; bus.req1_a = 16'h0100; bus.req1_b = 16'h0001;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n >= 20) begin
        errors++;
        $display("FAIL cont_grant_timeout op %0d got no ready want ready", k);
      end else if (bus.req1_ready !== 1'(k % 2) || bus.req0_ready !== 1'((k + 1) % 2)) begin
        errors++;
        $display("FAIL cont_grant op %0d got %b%b want id %0d", k, bus.req0_ready, bus.req1_ready, k % 2);
      end
      tick();
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (bus.rsp_id !== 1'(k % 2) || bus.rsp_data !== exp_data[k % 2]) begin
        errors++;
        $display("FAIL cont_rsp op %0d got id=%b data=%h want %0d %h", k, bus.rsp_id, bus.rsp_data, k % 2, exp_data[k % 2]);
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_backpressure();
    int n;
    bus.rsp_ready = 1'b0;
    bus.req0_op = OP_A; bus.req0_a = 16'h5A5A; bus.req0_b = 16'h0000;
    bus.req0_valid = 1'b1;
    #1;
    tick();  // accept
    bus.req1_valid = 1'b1;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h5A5A || bus.rsp_id !== 1'b0 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b data=%h id=%b rdy=%b%b busy=%b want 1 5a5a 0 00 1",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req0_ready, bus.req1_ready, bus.busy);
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();  // handshake
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got v=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_reset_settle();
    bus.rsp_ready = 1'b1;
    bus.req1_op = OP_B; bus.req1_a = 16'h1111; bus.req1_b = 16'h2222;
    bus.req1_valid = 1'b1;
    #1;
    tick();  // accept
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_settle_clear got a=%h b=%h busy=%b want 0 0 0", bus.alu_a, bus.alu_b, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_settle_norsp cyc %0d got %b want 0", i, bus.rsp_valid);
      end
      tick();
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_settle_ptr got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_all_ops();
    logic [15:0] exp_tab [8];
    int n;
    exp_tab[0] = 16'h00F0; exp_tab[1] = 16'h0F0F; exp_tab[2] = 16'h0FFF; exp_tab[3] = 16'hF1E1;
    exp_tab[4] = 16'h0000; exp_tab[5] = 16'h0FFF; exp_tab[6] = 16'h0FFF; exp_tab[7] = 16'hFF0F;
    bus.rsp_ready = 1'b1;
    bus.req1_a = 16'h00F0;
    bus.req1_b = 16'h0F0F;
    for (int op = 0; op < 8; op++) begin
      bus.req1_op = 3'(op);
      bus.req1_valid = 1'b1;
      #1;
      n = 0;
      while (bus.req1_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      tick();  // accept
      bus.req1_valid = 1'b0;
      checks++;
      if ({bus.alu_c1, bus.alu_c2, bus.alu_c3} !== 3'(op)) begin
        errors++;
        $display("FAIL ops_sel op %0d got %b want %b", op, {bus.alu_c1, bus.alu_c2, bus.alu_c3}, 3'(op));
      end
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_tab[op] || bus.rsp_id !== 1'b1) begin
        errors++;
        $display("FAIL ops_rsp op %0d got v=%b data=%h id=%b want 1 %h 1", op, bus.rsp_valid, bus.rsp_data, bus.rsp_id, exp_tab[op]);
      end
      tick();  // handshake
    end
  endtask

`ifdef ALU_SCHED_FLAGS_EN
  task automatic test_flags();
    logic [15:0] res_tab [2];
    logic        cout_tab [2];
    logic        zero_exp [2];
    int n;
    res_tab[0] = 16'h0000; cout_tab[0] = 1'b1; zero_exp[0] = 1'b1;
    res_tab[1] = 16'h0001; cout_tab[1] = 1'b0; zero_exp[1] = 1'b0;
    use_ovr = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ovr_val = res_tab[i];
      bus.alu_cout = cout_tab[i];
      bus.req0_op = OP_A;
      bus.req0_valid = 1'b1;
      #1;
      tick();
      bus.req0_valid = 1'b0;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (bus.rsp_zero !== zero_exp[i] || bus.rsp_carry !== cout_tab[i]) begin
        errors++;
        $display("FAIL flags case %0d got z=%b c=%b want %b %b", i, bus.rsp_zero, bus.rsp_carry, zero_exp[i], cout_tab[i]);
      end
      tick();
    end
    use_ovr = 1'b0;
    bus.alu_cout = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    use_ovr = 1'b0;
    ovr_val = 16'h0;
    bus.alu_cout = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_settle();
    test_all_ops();
`ifdef ALU_SCHED_FLAGS_EN
    test_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
